fineps_step_controller: RTL and testbench

Command-side initiator for the clock synthesizer's fine phase-shift port. It accepts a signed absolute phase-step target from user logic and tracks the current MMCM phase position. It issues one increment or decrement command per step to the synthesizer's `in_fineps_incr`/`in_fineps_decr`/`in_fineps_valid` inputs, paced by `out_fineps_dready`. It sits in the `in_fineps_clk` domain, between calibration/sweep logic and `clock_synthesizer`.

---
 rtl/fineps_step_controller.sv | 197 +++++++++++++++++++
 tb/tb_fineps_step_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fineps_step_controller.sv
// fineps_step_controller
//   Command-side initiator for the clock synthesizer fine phase-shift port.
//   It accepts a signed absolute step target, clamps it to +/-INT_POS_LIMIT,
//   and walks the MMCM phase one step at a time. Each step is one incr or decr
//   command, paced by the synthesizer's dready handshake.
//
// Ports
//   in_clk, in_rst           fine-PS clock; synchronous active-high reset
//   in_target_pos/valid      signed absolute target offer
//   out_target_ready         high in IDLE only (low during reset)
//   in_abort                 finish the in-flight step, then stop
//   out_fineps_incr/decr     one-cycle step commands to the synthesizer
//   out_fineps_valid         command qualifier to the synthesizer
//   in_fineps_dready         synthesizer ready (drops while a step executes)
//   out_cur_pos              signed position of completed steps
//   out_busy / out_done      not-IDLE flag / one-cycle completion pulse
//   out_err                  sticky: clamp applied or ack timeout
//
// Build option
//   FINEPS_CONST_VALID_EN    defined: out_fineps_valid is held high from the
//                            first cycle after reset. Undefined: valid pulses
//                            together with incr/decr.
module fineps_step_controller #(
  parameter int INT_POS_WIDTH     = 16,
  parameter int INT_POS_LIMIT     = 1120,
  parameter int INT_SETTLE_CYCLES = 4,
  parameter int INT_ACK_TIMEOUT   = 64
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic [INT_POS_WIDTH-1:0] in_target_pos,
  input  logic                     in_target_valid,
  output logic                     out_target_ready,
  input  logic                     in_abort,
  output logic                     out_fineps_incr,
  output logic                     out_fineps_decr,
  output logic                     out_fineps_valid,
  input  logic                     in_fineps_dready,
  output logic [INT_POS_WIDTH-1:0] out_cur_pos,
  output logic                     out_busy,
  output logic                     out_done,
  output logic                     out_err
);

  localparam int CNT_MAX = (INT_SETTLE_CYCLES > INT_ACK_TIMEOUT) ?
                           INT_SETTLE_CYCLES : INT_ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NEG_LIM = -INT_POS_LIMIT;

  localparam logic signed [INT_POS_WIDTH-1:0] POS_MAX = INT_POS_LIMIT[INT_POS_WIDTH-1:0];
  localparam logic signed [INT_POS_WIDTH-1:0] POS_MIN = NEG_LIM[INT_POS_WIDTH-1:0];
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(INT_ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(INT_SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, SETTLE, DONE
  } state_t;

  state_t                          state_q, state_d;
  logic signed [INT_POS_WIDTH-1:0] target_q, target_d;
  logic signed [INT_POS_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic                            abort_q, abort_d;
  logic                            dir_up_q, dir_up_d;
  logic                            ready_q, ready_d;
  logic                            incr, decr;

  logic signed [INT_POS_WIDTH-1:0] req_pos;
  logic signed [INT_POS_WIDTH-1:0] clamped_pos;
  logic                            clamp_hit;

  // Limits are inclusive: a target exactly at +/-INT_POS_LIMIT passes untouched.
  always_comb begin
    req_pos     = $signed(in_target_pos);
    clamped_pos = req_pos;
    clamp_hit   = 1'b0;
    if (req_pos > POS_MAX) begin
      clamped_pos = POS_MAX;
      clamp_hit   = 1'b1;
    end else if (req_pos < POS_MIN) begin
      clamped_pos = POS_MIN;
      clamp_hit   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    abort_d  = abort_q;
    dir_up_d = dir_up_q;
    incr     = 1'b0;
    decr     = 1'b0;

    if (state_q != IDLE && in_abort) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (in_target_valid && ready_q) begin
          target_d = clamped_pos;
          err_d    = clamp_hit;
          state_d  = (clamped_pos == pos_q) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Command is combinational on dready so the first pulse lands in the
        // cycle right after the target transfer.
        if (in_fineps_dready) begin
          dir_up_d = (target_q > pos_q);
          incr     = (target_q > pos_q);
          decr     = !(target_q > pos_q);
          cnt_d    = '0;
          state_d  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!in_fineps_dready) begin
          state_d = WAIT_HIGH;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (in_fineps_dready) begin
          pos_d   = dir_up_q ? pos_q + 1'b1 : pos_q - 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = (pos_q == target_q || abort_q || in_abort) ? DONE : ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered so ready stays low while in reset and rises one cycle later.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      dir_up_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      dir_up_q <= dir_up_d;
      ready_q  <= ready_d;
    end
  end

`ifdef FINEPS_CONST_VALID_EN
  logic valid_q, valid_d;

  always_comb valid_d = 1'b1;

  always_ff @(posedge in_clk) begin
    if (in_rst) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  assign out_fineps_valid = valid_q;
`else
  assign out_fineps_valid = incr | decr;
`endif

  assign out_fineps_incr  = incr;
  assign out_fineps_decr  = decr;
  assign out_target_ready = ready_q;
  assign out_cur_pos      = pos_q;
  assign out_busy         = (state_q != IDLE);
  assign out_done         = (state_q == DONE);
  assign out_err          = err_q;

endmodule

// File: tb/tb_fineps_step_controller.sv
// Testbench for fineps_step_controller: synthesizer handshake model plus a
// position/step reference model evaluated per sweep.
module tb_fineps_step_controller;

  localparam int W   = 16;
  localparam int LIM = 1120;
  localparam int SET = 4;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] tgt = '0;
  logic         tv  = 1'b0;
  logic         ab  = 1'b0;
  logic         rdy, inc, dec, vld, dready, busy, done, err;
  logic [W-1:0] pos;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pos  = 0;
  bit stuck    = 1'b0;

  always #5 clk = ~clk;

  fineps_step_controller #(
    .INT_POS_WIDTH    (W),
    .INT_POS_LIMIT    (LIM),
    .INT_SETTLE_CYCLES(SET),
    .INT_ACK_TIMEOUT  (TMO)
  ) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_target_pos   (tgt),
    .in_target_valid (tv),
    .out_target_ready(rdy),
    .in_abort        (ab),
    .out_fineps_incr (inc),
    .out_fineps_decr (dec),
    .out_fineps_valid(vld),
    .in_fineps_dready(dready),
    .out_cur_pos     (pos),
    .out_busy        (busy),
    .out_done        (done),
    .out_err         (err)
  );

  // Synthesizer model: dready drops 2 cycles after a command, rises 12 later.
  int unsigned scnt = 0;
  always @(posedge clk) begin
    if (rst)                           scnt <= 0;
    else if (vld && (inc || dec))      scnt <= 1;
    else if (scnt != 0 && scnt < 14)   scnt <= scnt + 1;
    else                               scnt <= 0;
  end
  assign dready = stuck ? 1'b1 : !(scnt >= 2 && scnt <= 13);

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int spos();
    return int'($signed(pos));
  endfunction

  // One target transfer and the complete sweep that follows it.
  // abort_at > 0 pulses in_abort right after that many commands.
  task automatic run(input string tag, input int req, input bit stuck_mode,
                     input int abort_at);
    int clamped, steps, want_pos, nin, ndec, cyc, limit;
    int first_p, last_p, gap_min, last_rise, bad_both, bad_valid;
    bit clampf, up, dprev;

    clamped = (req > LIM) ? LIM : (req < -LIM) ? -LIM : req;
    clampf  = (clamped != req);
    up      = (clamped > exp_pos);
    steps   = (clamped > exp_pos) ? clamped - exp_pos : exp_pos - clamped;
    if (stuck_mode) begin
      steps    = 1;
      want_pos = exp_pos;
    end else if (abort_at > 0) begin
      steps    = abort_at;
      want_pos = up ? exp_pos + abort_at : exp_pos - abort_at;
    end else begin
      want_pos = clamped;
    end
    stuck = stuck_mode;

    cyc = 0;
    while (!rdy && cyc < 50) begin @(negedge clk); cyc++; end
    check({tag, "_ready"}, int'(rdy), 1);

    tgt = req[W-1:0];
    tv  = 1'b1;
    @(negedge clk);
    tv  = 1'b0;
    check({tag, "_err_at_xfer"}, int'(err), int'(clampf));
    check({tag, "_busy"}, int'(busy), 1);

    nin = 0; ndec = 0; cyc = 0; first_p = -1; last_p = -1; gap_min = 1 << 30;
    last_rise = -1; bad_both = 0; bad_valid = 0; dprev = dready;
    limit = steps * 25 + TMO + 100;
    while (!done && cyc < limit) begin
      ab = 1'b0;
      if (inc && dec) bad_both++;
`ifdef FINEPS_CONST_VALID_EN
      if (vld !== 1'b1) bad_valid++;
`else
      if (vld !== (inc | dec)) bad_valid++;
`endif
      if (inc || dec) begin
        if (inc) nin++;
        if (dec) ndec++;
        if (first_p < 0) first_p = cyc;
        if (last_p >= 0 && cyc - last_p < gap_min) gap_min = cyc - last_p;
        last_p = cyc;
        if (abort_at > 0 && nin + ndec == abort_at) ab = 1'b1;
      end
      if (dready && !dprev) last_rise = cyc;
      dprev = dready;
      @(negedge clk);
      cyc++;
    end
    ab = 1'b0;

    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_pulses_dir"}, up ? nin : ndec, steps);
    check({tag, "_pulses_wrong"}, up ? ndec : nin, 0);
    check({tag, "_both_high"}, bad_both, 0);
    check({tag, "_valid_rule"}, bad_valid, 0);
    if (steps > 0) check({tag, "_first_latency"}, first_p, 0);
    if (steps > 1) check({tag, "_min_gap_ok"}, int'(gap_min >= 14 + SET), 1);
    if (stuck_mode)
      check({tag, "_tmo_latency"}, cyc - first_p, TMO + 1);
    else if (steps > 0)
      check({tag, "_rise_to_done"}, cyc - last_rise, SET + 1);

    @(negedge clk);
    check({tag, "_done_single"}, int'(done), 0);
    check({tag, "_pos"}, spos(), want_pos);
    check({tag, "_err"}, int'(err), int'(clampf || stuck_mode));
    check({tag, "_idle_ready"}, int'(rdy), 1);
    check({tag, "_idle_busy"}, int'(busy), 0);
    exp_pos = want_pos;
    stuck   = 1'b0;
  endtask

  initial begin
    int cyc, r;

    repeat (3) @(negedge clk);
    check("rst_ready", int'(rdy), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmd", int'({inc, dec, vld}), 0);
    check("rst_pos", spos(), 0);
    check("rst_err_done", int'({err, done}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(rdy), 1);
`ifdef FINEPS_CONST_VALID_EN
    check("post_rst_valid", int'(vld), 1);
`else
    check("post_rst_valid", int'(vld), 0);
`endif

    run("up360",   360,   1'b0, 0);
    run("dn360",  -360,   1'b0, 0);
    run("clampN", -5000,  1'b0, 0);
    run("edgeN",  -1120,  1'b0, 0);
    run("zero",    0,     1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      r = int'($urandom_range(40)) - 20;
      run("rand", exp_pos + r, 1'b0, 0);
    end
    run("abort", exp_pos + 100, 1'b0, 3);
    run("tmo",   exp_pos + 1,   1'b1, 0);

    // Reset while a sweep is running.
    tgt = 16'd50;
    tv  = 1'b1;
    @(negedge clk);
    tv  = 1'b0;
    cyc = 0;
    r   = 0;
    while (r < 5 && cyc < 500) begin
      if (inc || dec) r++;
      @(negedge clk);
      cyc++;
    end
    check("mid_pulses_reached", r, 5);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", int'({inc, dec, vld}), 0);
    check("mid_rst_status", int'({rdy, busy, done, err}), 0);
    check("mid_rst_pos", spos(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", int'(rdy), 1);
    exp_pos = 0;
    run("after_rst", 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
